hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard and stall controller; the producer of the stall/flush controls consumed by the IF/ID, ID/EX and EX/MEM pipeline registers and the PC register.
- Detects load-use hazards between ID and EX, and branch/jump redirects resolved in EX.
- Tracks multi-cycle data-memory waits and halt retirement, and drives the matching stall/flush/bubble controls and a stall performance counter.

Parameters:
- CNT_WIDTH, 32, width of the stall-cycle performance counter (saturating).
- MEM_TIMEOUT, 1024, consecutive data-memory wait cycles after which o_mem_timeout sets; 0 disables the timeout.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- i_id_valid  in  1  ID stage holds a valid instruction.
- i_id_rs1_addr  in  5  ID rs1 address.
- i_id_rs2_addr  in  5  ID rs2 address.
- i_id_rs1_used  in  1  ID instruction reads rs1.
- i_id_rs2_used  in  1  ID instruction reads rs2.
- i_ex_valid  in  1  EX stage (ID/EX output) valid.
- i_ex_rd_addr  in  5  EX destination register.
- i_ex_mem_read  in  1  EX instruction is a load.
- i_ex_redirect  in  1  EX resolved a taken jump or mispredicted branch.
- i_mem_req  in  1  MEM stage has a valid load/store in flight.
- i_dmem_ready  in  1  data memory completes the MEM-stage access this cycle.
- i_wb_valid  in  1  WB instruction valid.
- i_wb_halt  in  1  WB instruction is a halt.
- o_pc_stall  out  1  hold PC.
- o_if_id_stall  out  1  hold IF/ID.
- o_if_id_flush  out  1  clear IF/ID to bubble.
- o_id_ex_stall  out  1  hold ID/EX.
- o_id_ex_flush  out  1  load bubble (valid=0, all control 0) into ID/EX.
- o_ex_mem_stall  out  1  hold EX/MEM.
- o_halted  out  1  core halted (sticky).
- o_mem_timeout  out  1  sticky data-memory timeout flag.
- o_stall_cycles  out  CNT_WIDTH  count of cycles with o_pc_stall=1 outside HALTED.

Behaviour:
- State machine: RUN, MEM_WAIT, HALTED.
- Reset: state=RUN; o_halted=0, o_mem_timeout=0, o_stall_cycles=0, wait counter=0. During reset cycles all stall/flush outputs are 0.
- Reset mid-operation returns to RUN from any state on the next edge.
- Stall/flush outputs are combinational from state and current inputs (zero latency). Registered state, flags and counters update on the i_clk rising edge.
- mem_stall = (state==MEM_WAIT) | (state==RUN & i_mem_req & !i_dmem_ready).
- load_use = i_ex_valid & i_ex_mem_read & i_ex_rd_addr!=0 & i_id_valid & ((i_id_rs1_used & rs1==rd) | (i_id_rs2_used & rs2==rd)).
- redirect = i_ex_valid & i_ex_redirect.
- Output priority, highest first: HALTED > mem_stall > redirect > load_use > none.
  - HALTED: all four stalls=1, o_id_ex_flush=1, o_if_id_flush=0.
  - mem_stall: all four stalls=1, both flushes=0. A redirect or load-use present during the wait is held frozen and acted on once ready.
  - redirect: o_if_id_flush=1, o_id_ex_flush=1, no stalls. The load-use stall is suppressed because the younger instruction is killed.
  - load_use: o_pc_stall=1, o_if_id_stall=1, o_id_ex_flush=1, o_ex_mem_stall=0. Exactly one bubble; the hazard clears the next cycle as the load advances.
  - none: all outputs 0.
- Transitions:
  - RUN→MEM_WAIT when i_mem_req & !i_dmem_ready.
  - MEM_WAIT→RUN on a cycle with i_dmem_ready=1; stalls remain 1 in that cycle, and the pipeline advances on the following cycle.
  - Any state except HALTED→HALTED when i_wb_valid & i_wb_halt, including MEM_WAIT. Halt wins over a simultaneous memory wait.
  - HALTED exits only on reset.
- Wait counter: cleared on entry to MEM_WAIT and in RUN; increments each MEM_WAIT cycle. When it reaches MEM_TIMEOUT (MEM_TIMEOUT≠0), o_mem_timeout←1 (sticky until reset); the state stays MEM_WAIT.
- o_stall_cycles: +1 on each edge where o_pc_stall=1 and state≠HALTED; saturates at all-ones, no wrap.
- o_halted = (state==HALTED).

Decomposition:
- Shared package holds:
  - State encoding constants: RUN=2'd0, MEM_WAIT=2'd1, HALTED=2'd2.
  - The x0 register index constant.
- One sub-module, sat_counter (parameter WIDTH; enable, synchronous clear, saturating q). It is instantiated for o_stall_cycles and for the wait counter.
- The hazard compares stay in the top level.

Test Plan:
- Load-use: EX lw x5 (i_ex_mem_read=1, rd=5); ID add using rs1=5, rs1_used=1 → same cycle o_pc_stall=1, o_if_id_stall=1, o_id_ex_flush=1; next cycle with EX bubble → all 0; o_stall_cycles=1.
- x0 and unused operands:
  - Same as the load-use case but rd=0 → no stall.
  - rs2=5 with rs2_used=0 → no stall.
- Redirect plus load-use in the same cycle → o_if_id_flush=1, o_id_ex_flush=1, o_pc_stall=0, counter unchanged.
- Memory wait: i_mem_req=1, i_dmem_ready=0 for 3 cycles, then 1 → all stalls=1 for 4 cycles and flushes 0; state back in RUN after the ready cycle; o_stall_cycles=4.
- Timeout: MEM_TIMEOUT=4, ready held 0 for 6 cycles → o_mem_timeout=1 after the 4th MEM_WAIT edge and stays 1 after ready; cleared only by i_rst.
- Halt: i_wb_valid=1, i_wb_halt=1 during MEM_WAIT → next cycle o_halted=1, all stalls=1, o_id_ex_flush=1; counter frozen; i_rst=1 → o_halted=0, counter=0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller.
// Holds the state encoding, the x0 index and the operand-match helper.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALTED   = 2'd2
  } state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

  // True when an ID source operand is actually read and names the EX destination.
  function automatic logic src_hit(input logic used, input logic [4:0] src, input logic [4:0] dst);
    return used && (src == dst);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_q = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall controller: load-use, EX redirect, data-memory wait
// and halt handling, plus a saturating stall-cycle counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH   = 32,
  parameter int MEM_TIMEOUT = 1024
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_id_valid,
  input  logic [4:0]           i_id_rs1_addr,
  input  logic [4:0]           i_id_rs2_addr,
  input  logic                 i_id_rs1_used,
  input  logic                 i_id_rs2_used,
  input  logic                 i_ex_valid,
  input  logic [4:0]           i_ex_rd_addr,
  input  logic                 i_ex_mem_read,
  input  logic                 i_ex_redirect,
  input  logic                 i_mem_req,
  input  logic                 i_dmem_ready,
  input  logic                 i_wb_valid,
  input  logic                 i_wb_halt,
  output logic                 o_pc_stall,
  output logic                 o_if_id_stall,
  output logic                 o_if_id_flush,
  output logic                 o_id_ex_stall,
  output logic                 o_id_ex_flush,
  output logic                 o_ex_mem_stall,
  output logic                 o_halted,
  output logic                 o_mem_timeout,
  output logic [CNT_WIDTH-1:0] o_stall_cycles
);

  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  // Timeout fires on the MEM_WAIT edge that moves the wait counter onto MEM_TIMEOUT.
  localparam logic [WAIT_W-1:0] TIMEOUT_LAST = WAIT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  state_e            state_q;
  state_e            state_d;
  logic              timeout_q;
  logic              timeout_d;
  logic [WAIT_W-1:0] wait_cnt;

  logic mem_stall;
  logic load_use;
  logic redirect;
  logic halt_req;

  assign mem_stall = (state_q == MEM_WAIT) ||
                     ((state_q == RUN) && i_mem_req && !i_dmem_ready);
  assign load_use  = i_ex_valid && i_ex_mem_read && (i_ex_rd_addr != REG_X0) && i_id_valid &&
                     (src_hit(i_id_rs1_used, i_id_rs1_addr, i_ex_rd_addr) ||
                      src_hit(i_id_rs2_used, i_id_rs2_addr, i_ex_rd_addr));
  assign redirect  = i_ex_valid && i_ex_redirect;
  assign halt_req  = i_wb_valid && i_wb_halt;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (halt_req) begin
          state_d = HALTED;
        end else if (i_mem_req && !i_dmem_ready) begin
          state_d = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (halt_req) begin
          state_d = HALTED;
        end else if (i_dmem_ready) begin
          state_d = RUN;
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    o_pc_stall     = 1'b0;
    o_if_id_stall  = 1'b0;
    o_if_id_flush  = 1'b0;
    o_id_ex_stall  = 1'b0;
    o_id_ex_flush  = 1'b0;
    o_ex_mem_stall = 1'b0;
    if (i_rst) begin
      o_pc_stall = 1'b0;
    end else if (state_q == HALTED) begin
      o_pc_stall     = 1'b1;
      o_if_id_stall  = 1'b1;
      o_id_ex_stall  = 1'b1;
      o_ex_mem_stall = 1'b1;
      o_id_ex_flush  = 1'b1;
    end else if (mem_stall) begin
      // Freeze everything; a pending redirect or load-use is re-evaluated once ready.
      o_pc_stall     = 1'b1;
      o_if_id_stall  = 1'b1;
      o_id_ex_stall  = 1'b1;
      o_ex_mem_stall = 1'b1;
    end else if (redirect) begin
      o_if_id_flush = 1'b1;
      o_id_ex_flush = 1'b1;
    end else if (load_use) begin
      o_pc_stall    = 1'b1;
      o_if_id_stall = 1'b1;
      o_id_ex_flush = 1'b1;
    end
  end

  always_comb begin
    timeout_d = timeout_q;
    if ((MEM_TIMEOUT != 0) && (state_q == MEM_WAIT) && (wait_cnt == TIMEOUT_LAST)) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= RUN;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_d;
    end
  end

  sat_counter #(
    .WIDTH (WAIT_W)
  ) u_wait_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (state_q != MEM_WAIT),
    .i_en  (state_q == MEM_WAIT),
    .o_q   (wait_cnt)
  );

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_stall_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (1'b0),
    .i_en  (o_pc_stall && (state_q != HALTED)),
    .o_q   (o_stall_cycles)
  );

  assign o_halted      = (state_q == HALTED);
  assign o_mem_timeout = timeout_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: each step pushes the expected controls/flags
// and pops them for comparison once the DUT has settled for that cycle.
module tb_hazard_ctrl;

  typedef struct packed {
    logic       rst;
    logic       id_valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1_used;
    logic       rs2_used;
    logic       ex_valid;
    logic [4:0] ex_rd;
    logic       ex_mem_read;
    logic       ex_redirect;
    logic       mem_req;
    logic       dmem_ready;
    logic       wb_valid;
    logic       wb_halt;
  } stim_t;

  typedef struct packed {
    logic [5:0] ctl;
    logic       halted;
    logic       timeout;
    logic [3:0] cnt;
  } exp_t;

  // ctl bit order: pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall
  localparam logic [5:0] C_NONE = 6'b000000;
  localparam logic [5:0] C_LU   = 6'b110010;
  localparam logic [5:0] C_RD   = 6'b001010;
  localparam logic [5:0] C_MEM  = 6'b110101;
  localparam logic [5:0] C_HALT = 6'b110111;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_rs1_used;
  logic       id_rs2_used;
  logic       ex_valid;
  logic [4:0] ex_rd;
  logic       ex_mem_read;
  logic       ex_redirect;
  logic       mem_req;
  logic       dmem_ready;
  logic       wb_valid;
  logic       wb_halt;
  logic       pc_stall;
  logic       if_id_stall;
  logic       if_id_flush;
  logic       id_ex_stall;
  logic       id_ex_flush;
  logic       ex_mem_stall;
  logic       halted;
  logic       mem_timeout;
  logic [3:0] stall_cycles;

  int   tests_run    = 0;
  int   tests_failed = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  hazard_ctrl #(
    .CNT_WIDTH   (4),
    .MEM_TIMEOUT (4)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_id_valid     (id_valid),
    .i_id_rs1_addr  (id_rs1),
    .i_id_rs2_addr  (id_rs2),
    .i_id_rs1_used  (id_rs1_used),
    .i_id_rs2_used  (id_rs2_used),
    .i_ex_valid     (ex_valid),
    .i_ex_rd_addr   (ex_rd),
    .i_ex_mem_read  (ex_mem_read),
    .i_ex_redirect  (ex_redirect),
    .i_mem_req      (mem_req),
    .i_dmem_ready   (dmem_ready),
    .i_wb_valid     (wb_valid),
    .i_wb_halt      (wb_halt),
    .o_pc_stall     (pc_stall),
    .o_if_id_stall  (if_id_stall),
    .o_if_id_flush  (if_id_flush),
    .o_id_ex_stall  (id_ex_stall),
    .o_id_ex_flush  (id_ex_flush),
    .o_ex_mem_stall (ex_mem_stall),
    .o_halted       (halted),
    .o_mem_timeout  (mem_timeout),
    .o_stall_cycles (stall_cycles)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input stim_t s);
    rst         = s.rst;
    id_valid    = s.id_valid;
    id_rs1      = s.rs1;
    id_rs2      = s.rs2;
    id_rs1_used = s.rs1_used;
    id_rs2_used = s.rs2_used;
    ex_valid    = s.ex_valid;
    ex_rd       = s.ex_rd;
    ex_mem_read = s.ex_mem_read;
    ex_redirect = s.ex_redirect;
    mem_req     = s.mem_req;
    dmem_ready  = s.dmem_ready;
    wb_valid    = s.wb_valid;
    wb_halt     = s.wb_halt;
  endtask

  function automatic stim_t s_idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t s_lu(input logic [4:0] rd, input logic [4:0] r1, input logic u1,
                                 input logic [4:0] r2, input logic u2);
    stim_t s;
    s = '0;
    s.id_valid    = 1'b1;
    s.rs1         = r1;
    s.rs1_used    = u1;
    s.rs2         = r2;
    s.rs2_used    = u2;
    s.ex_valid    = 1'b1;
    s.ex_rd       = rd;
    s.ex_mem_read = 1'b1;
    return s;
  endfunction

  function automatic stim_t s_mem(input logic ready);
    stim_t s;
    s = '0;
    s.mem_req    = 1'b1;
    s.dmem_ready = ready;
    return s;
  endfunction

  // One cycle: drive at the falling edge, compare settled outputs 1ns later.
  task automatic step(input string name, input stim_t s, input logic [5:0] ctl,
                      input logic h, input logic to, input int cnt);
    exp_t e;
    exp_t want;
    logic [5:0] got_ctl;
    @(negedge clk);
    drive(s);
    e.ctl     = ctl;
    e.halted  = h;
    e.timeout = to;
    e.cnt     = 4'(cnt);
    sb_q.push_back(e);
    #1;
    want    = sb_q.pop_front();
    got_ctl = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall};
    check({name, " ctl"},     32'(got_ctl),      32'(want.ctl));
    check({name, " halted"},  32'(halted),       32'(want.halted));
    check({name, " timeout"}, 32'(mem_timeout),  32'(want.timeout));
    check({name, " stalls"},  32'(stall_cycles), 32'(want.cnt));
    $display("[TB] %s ctl=%b halted=%b timeout=%b stalls=%0d", name, got_ctl, halted,
             mem_timeout, stall_cycles);
  endtask

  initial begin
    stim_t s;
    s = s_idle();
    s.rst = 1'b1;
    drive(s);
    repeat (2) @(posedge clk);

    // Reset and load-use detection
    s = s_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0); s.rst = 1'b1;
    step("rst_gate", s, C_NONE, 0, 0, 0);
    step("lu_rs1", s_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0), C_LU, 0, 0, 0);
    step("lu_clear", s_idle(), C_NONE, 0, 0, 1);
    step("lu_x0", s_lu(5'd0, 5'd0, 1'b1, 5'd0, 1'b0), C_NONE, 0, 0, 1);
    step("lu_rs2_unused", s_lu(5'd5, 5'd3, 1'b1, 5'd5, 1'b0), C_NONE, 0, 0, 1);
    step("lu_rs2", s_lu(5'd5, 5'd3, 1'b1, 5'd5, 1'b1), C_LU, 0, 0, 1);
    s = s_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0); s.ex_redirect = 1'b1;
    step("redir_lu", s, C_RD, 0, 0, 2);
    step("redir_after", s_idle(), C_NONE, 0, 0, 2);

    // Memory wait with a frozen redirect released after ready
    s = s_idle(); s.rst = 1'b1;
    step("rst_mem", s, C_NONE, 0, 0, 2);
    step("mem_w0", s_mem(1'b0), C_MEM, 0, 0, 0);
    step("mem_w1", s_mem(1'b0), C_MEM, 0, 0, 1);
    step("mem_w2", s_mem(1'b0), C_MEM, 0, 0, 2);
    s = s_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0); s.ex_redirect = 1'b1;
    s.mem_req = 1'b1; s.dmem_ready = 1'b1;
    step("mem_ready", s, C_MEM, 0, 0, 3);
    s.mem_req = 1'b0; s.dmem_ready = 1'b0;
    step("mem_release", s, C_RD, 0, 0, 4);
    step("mem_idle", s_idle(), C_NONE, 0, 0, 4);

    // Timeout after the fourth MEM_WAIT edge
    s = s_idle(); s.rst = 1'b1;
    step("rst_to", s, C_NONE, 0, 0, 4);
    step("to_w0", s_mem(1'b0), C_MEM, 0, 0, 0);
    step("to_w1", s_mem(1'b0), C_MEM, 0, 0, 1);
    step("to_w2", s_mem(1'b0), C_MEM, 0, 0, 2);
    step("to_w3", s_mem(1'b0), C_MEM, 0, 0, 3);
    step("to_w4", s_mem(1'b0), C_MEM, 0, 0, 4);
    step("to_w5", s_mem(1'b0), C_MEM, 0, 1, 5);
    step("to_ready", s_mem(1'b1), C_MEM, 0, 1, 6);
    step("to_sticky", s_idle(), C_NONE, 0, 1, 7);

    // Stall counter saturation
    for (int i = 1; i <= 10; i++) begin
      step($sformatf("sat_%0d", i), s_mem(1'b0), C_MEM, 0, 1, ((6 + i) > 15) ? 15 : (6 + i));
    end
    s = s_idle(); s.rst = 1'b1;
    step("rst_sat", s, C_NONE, 0, 1, 15);

    // Halt during MEM_WAIT, then from RUN against a simultaneous wait
    step("halt_w0", s_mem(1'b0), C_MEM, 0, 0, 0);
    s = s_mem(1'b0); s.wb_valid = 1'b1; s.wb_halt = 1'b1;
    step("halt_req", s, C_MEM, 0, 0, 1);
    step("halted_idle", s_idle(), C_HALT, 1, 0, 2);
    s = s_mem(1'b1); s.ex_valid = 1'b1; s.ex_redirect = 1'b1;
    step("halted_hold", s, C_HALT, 1, 0, 2);
    s = s_idle(); s.rst = 1'b1;
    step("rst_halt", s, C_NONE, 1, 0, 2);
    step("post_rst", s_idle(), C_NONE, 0, 0, 0);
    s = s_mem(1'b0); s.wb_valid = 1'b1; s.wb_halt = 1'b1;
    step("halt_vs_wait", s, C_MEM, 0, 0, 0);
    step("halt_won", s_idle(), C_HALT, 1, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
